// File: rtl/id_ex_stage.sv
// ID/EX pipeline register feeding the ALU.
// Holds the decoded operands and control bits, and forwards operands from
// EX/MEM and MEM/WB on the way out. While stalled it re-captures the
// forwarded operands so that a producer retiring mid-stall is not lost.
module id_ex_stage #(
   parameter int DW = 32,
   parameter int RW = 5
) (
   input  logic          CLK,
   input  logic          RST,
   input  logic          id_valid,
   input  logic [DW-1:0] id_rdat1,
   input  logic [DW-1:0] id_rdat2,
   input  logic [DW-1:0] id_imm,
   input  logic          id_alusrc,
   input  logic [3:0]    id_aluop,
   input  logic [RW-1:0] id_rs,
   input  logic [RW-1:0] id_rt,
   input  logic [RW-1:0] id_wsel,
   input  logic          id_regwen,
   input  logic          stall,
   input  logic          flush,
   input  logic          exmem_regwen,
   input  logic [RW-1:0] exmem_wsel,
   input  logic [DW-1:0] exmem_result,
   input  logic          memwb_regwen,
   input  logic [RW-1:0] memwb_wsel,
   input  logic [DW-1:0] memwb_wdat,
   output logic [DW-1:0] PortA,
   output logic [DW-1:0] PortB,
   output logic [3:0]    ALUOP,
   output logic          ex_valid,
   output logic          ex_regwen,
   output logic [RW-1:0] ex_wsel,
   output logic [DW-1:0] ex_store_dat,
   output logic [1:0]    fwd_a_sel,
   output logic [1:0]    fwd_b_sel
);

   localparam logic [1:0] SEL_REG   = 2'd0;
   localparam logic [1:0] SEL_EXMEM = 2'd1;
   localparam logic [1:0] SEL_MEMWB = 2'd2;

   // registered stage contents
   logic          r_valid;
   logic [DW-1:0] r_rdat1;
   logic [DW-1:0] r_rdat2;
   logic [DW-1:0] r_imm;
   logic          r_alusrc;
   logic [3:0]    r_aluop;
   logic [RW-1:0] r_rs;
   logic [RW-1:0] r_rt;
   logic [RW-1:0] r_wsel;
   logic          r_regwen;

   logic [DW-1:0] fwd_a;
   logic [DW-1:0] fwd_b;

   // operand A source: EX/MEM beats MEM/WB, r0 is never forwarded
   always_comb begin
      fwd_a_sel = SEL_REG;
      fwd_a     = r_rdat1;
      if (exmem_regwen && (exmem_wsel == r_rs) && (r_rs != '0)) begin
         fwd_a_sel = SEL_EXMEM;
         fwd_a     = exmem_result;
      end else if (memwb_regwen && (memwb_wsel == r_rs) && (r_rs != '0)) begin
         fwd_a_sel = SEL_MEMWB;
         fwd_a     = memwb_wdat;
      end
   end

   // operand B source: same rule applied to rt
   always_comb begin
      fwd_b_sel = SEL_REG;
      fwd_b     = r_rdat2;
      if (exmem_regwen && (exmem_wsel == r_rt) && (r_rt != '0)) begin
         fwd_b_sel = SEL_EXMEM;
         fwd_b     = exmem_result;
      end else if (memwb_regwen && (memwb_wsel == r_rt) && (r_rt != '0)) begin
         fwd_b_sel = SEL_MEMWB;
         fwd_b     = memwb_wdat;
      end
   end

   // stage register: reset/flush -> bubble, stall -> hold control and
   // latch the forwarded operands, otherwise load from decode
   always_ff @(posedge CLK) begin
      if (RST || flush) begin
         r_valid  <= 1'b0;
         r_rdat1  <= '0;
         r_rdat2  <= '0;
         r_imm    <= '0;
         r_alusrc <= 1'b0;
         r_aluop  <= 4'h0;
         r_rs     <= '0;
         r_rt     <= '0;
         r_wsel   <= '0;
         r_regwen <= 1'b0;
      end else if (stall) begin
         r_rdat1 <= fwd_a;
         r_rdat2 <= fwd_b;
      end else begin
         r_valid  <= id_valid;
         r_rdat1  <= id_rdat1;
         r_rdat2  <= id_rdat2;
         r_imm    <= id_imm;
         r_alusrc <= id_alusrc;
         r_aluop  <= id_aluop;
         r_rs     <= id_rs;
         r_rt     <= id_rt;
         r_wsel   <= id_wsel;
         r_regwen <= id_regwen;
      end
   end

   assign PortA        = fwd_a;
   assign PortB        = r_alusrc ? r_imm : fwd_b;
   assign ex_store_dat = fwd_b;
   assign ALUOP        = r_aluop;
   assign ex_valid     = r_valid;
   assign ex_regwen    = r_regwen;
   assign ex_wsel      = r_wsel;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed cases with literal expectations, then
// randomized traffic checked every cycle against a behavioural model.
module tb_id_ex_stage;

   localparam int DW = 32;
   localparam int RW = 5;

   logic          CLK = 1'b0;
   logic          RST;
   logic          id_valid, id_alusrc, id_regwen;
   logic [DW-1:0] id_rdat1, id_rdat2, id_imm;
   logic [3:0]    id_aluop;
   logic [RW-1:0] id_rs, id_rt, id_wsel;
   logic          stall, flush;
   logic          exmem_regwen, memwb_regwen;
   logic [RW-1:0] exmem_wsel, memwb_wsel;
   logic [DW-1:0] exmem_result, memwb_wdat;
   logic [DW-1:0] PortA, PortB, ex_store_dat;
   logic [3:0]    ALUOP;
   logic          ex_valid, ex_regwen;
   logic [RW-1:0] ex_wsel;
   logic [1:0]    fwd_a_sel, fwd_b_sel;

   int checks = 0;
   int failures = 0;

   id_ex_stage #(.DW(DW), .RW(RW)) dut (
      .CLK(CLK), .RST(RST),
      .id_valid(id_valid), .id_rdat1(id_rdat1), .id_rdat2(id_rdat2),
      .id_imm(id_imm), .id_alusrc(id_alusrc), .id_aluop(id_aluop),
      .id_rs(id_rs), .id_rt(id_rt), .id_wsel(id_wsel), .id_regwen(id_regwen),
      .stall(stall), .flush(flush),
      .exmem_regwen(exmem_regwen), .exmem_wsel(exmem_wsel), .exmem_result(exmem_result),
      .memwb_regwen(memwb_regwen), .memwb_wsel(memwb_wsel), .memwb_wdat(memwb_wdat),
      .PortA(PortA), .PortB(PortB), .ALUOP(ALUOP),
      .ex_valid(ex_valid), .ex_regwen(ex_regwen), .ex_wsel(ex_wsel),
      .ex_store_dat(ex_store_dat), .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // What the instruction sitting in EX carries.
   typedef struct packed {
      logic          valid;
      logic [DW-1:0] a;
      logic [DW-1:0] b;
      logic [DW-1:0] imm;
      logic          alusrc;
      logic [3:0]    op;
      logic [RW-1:0] rs;
      logic [RW-1:0] rt;
      logic [RW-1:0] wsel;
      logic          regwen;
   } slot_t;

   slot_t m;
   bit    model_ok = 0;

   // Youngest live producer of register idx, as {source code, value}.
   function automatic logic [33:0] newest(input logic [RW-1:0] idx, input logic [DW-1:0] held);
      if (idx == 0) return {2'd0, held};
      if (exmem_regwen && exmem_wsel == idx) return {2'd1, exmem_result};
      if (memwb_regwen && memwb_wsel == idx) return {2'd2, memwb_wdat};
      return {2'd0, held};
   endfunction

   always @(posedge CLK) begin
      if (RST) model_ok <= 1;
      if (RST || flush) m <= '0;
      else if (stall) begin
         m.a <= newest(m.rs, m.a);
         m.b <= newest(m.rt, m.b);
      end else
         m <= {id_valid, id_rdat1, id_rdat2, id_imm, id_alusrc, id_aluop,
               id_rs, id_rt, id_wsel, id_regwen};
   end

   // compare process: outputs vs model every cycle once reset has been seen
   always @(negedge CLK) begin
      if (model_ok) begin
         logic [33:0] fa, fb;
         fa = newest(m.rs, m.a);
         fb = newest(m.rt, m.b);
         chk("m_PortA",     PortA,        fa[31:0]);
         chk("m_PortB",     PortB,        m.alusrc ? m.imm : fb[31:0]);
         chk("m_store",     ex_store_dat, fb[31:0]);
         chk("m_ALUOP",     {28'd0, ALUOP},       {28'd0, m.op});
         chk("m_valid",     {31'd0, ex_valid},    {31'd0, m.valid});
         chk("m_regwen",    {31'd0, ex_regwen},   {31'd0, m.regwen});
         chk("m_wsel",      {27'd0, ex_wsel},     {27'd0, m.wsel});
         chk("m_fwd_a_sel", {30'd0, fwd_a_sel},   {30'd0, fa[33:32]});
         chk("m_fwd_b_sel", {30'd0, fwd_b_sel},   {30'd0, fb[33:32]});
      end
   end

   // ---------------- stimulus ----------------
   task automatic cyc();
      @(posedge CLK);
      #2;
   endtask

   task automatic set_id(input logic v, input logic [31:0] r1, input logic [31:0] r2,
                         input logic [31:0] imm, input logic src, input logic [3:0] op,
                         input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] ws, input logic wen);
      id_valid = v; id_rdat1 = r1; id_rdat2 = r2; id_imm = imm; id_alusrc = src;
      id_aluop = op; id_rs = rs; id_rt = rt; id_wsel = ws; id_regwen = wen;
   endtask

   task automatic set_prod(input logic ew, input logic [4:0] es, input logic [31:0] er,
                           input logic mw, input logic [4:0] ms, input logic [31:0] md);
      exmem_regwen = ew; exmem_wsel = es; exmem_result = er;
      memwb_regwen = mw; memwb_wsel = ms; memwb_wdat = md;
   endtask

   task automatic rand_id();
      set_id(1'($urandom), $urandom, $urandom, $urandom, 1'($urandom), 4'($urandom),
             5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom), 1'($urandom));
   endtask

   initial begin
      RST = 1; stall = 0; flush = 0;
      rand_id();
      set_prod(0, 0, 0, 0, 0, 0);

      // reset: two cycles with garbage on decode
      cyc(); rand_id();
      cyc();
      chk("rst_PortA", PortA, 0);
      chk("rst_PortB", PortB, 0);
      chk("rst_ALUOP", {28'd0, ALUOP}, 0);
      chk("rst_valid", {31'd0, ex_valid}, 0);
      chk("rst_regwen", {31'd0, ex_regwen}, 0);
      chk("rst_wsel", {27'd0, ex_wsel}, 0);
      chk("rst_store", ex_store_dat, 0);
      chk("rst_sel", {28'd0, fwd_a_sel, fwd_b_sel}, 0);
      RST = 0;

      // plain load
      set_id(1, 32'd5, 32'd7, 32'd0, 0, 4'h2, 5'd1, 5'd2, 5'd3, 1);
      cyc();
      #1;
      chk("load_PortA", PortA, 5);
      chk("load_PortB", PortB, 7);
      chk("load_sel", {28'd0, fwd_a_sel, fwd_b_sel}, 0);
      chk("load_valid", {31'd0, ex_valid}, 1);

      // double hazard on r3
      set_id(1, 32'd11, 32'd22, 32'd0, 0, 4'h2, 5'd3, 5'd3, 5'd9, 1);
      cyc();
      set_prod(1, 5'd3, 32'hAAAA0000, 1, 5'd3, 32'h5555);
      #1;
      chk("dh_exmem_A", PortA, 32'hAAAA0000);
      chk("dh_exmem_B", PortB, 32'hAAAA0000);
      chk("dh_exmem_sel", {28'd0, fwd_a_sel, fwd_b_sel}, 32'h5);
      exmem_wsel = 5'd4;
      #1;
      chk("dh_memwb_A", PortA, 32'h5555);
      chk("dh_memwb_B", PortB, 32'h5555);
      chk("dh_memwb_sel", {28'd0, fwd_a_sel, fwd_b_sel}, 32'hA);

      // r0 never forwarded
      set_prod(0, 0, 0, 0, 0, 0);
      set_id(1, 32'h77, 32'h88, 32'd0, 0, 4'h2, 5'd0, 5'd0, 5'd1, 1);
      cyc();
      set_prod(1, 5'd0, 32'hDEAD, 1, 5'd0, 32'hBEEF);
      #1;
      chk("r0_PortA", PortA, 32'h77);
      chk("r0_PortB", PortB, 32'h88);
      chk("r0_sel", {28'd0, fwd_a_sel, fwd_b_sel}, 0);

      // immediate selected, store data still forwarded
      set_prod(0, 0, 0, 0, 0, 0);
      set_id(1, 32'h1, 32'h100, 32'hFFFFFFFC, 1, 4'h2, 5'd7, 5'd6, 5'd2, 0);
      cyc();
      set_prod(1, 5'd6, 32'd9, 0, 0, 0);
      #1;
      chk("imm_PortB", PortB, 32'hFFFFFFFC);
      chk("imm_store", ex_store_dat, 32'd9);
      chk("imm_bsel", {30'd0, fwd_b_sel}, 1);

      // stall capture of a MEM/WB value that retires mid-stall
      set_prod(0, 0, 0, 0, 0, 0);
      set_id(1, 32'h99, 32'h0, 32'h0, 0, 4'h7, 5'd5, 5'd8, 5'd10, 1);
      cyc();
      set_prod(0, 0, 0, 1, 5'd5, 32'h1234);
      stall = 1;
      rand_id();
      #1;
      chk("stl_fwd_A", PortA, 32'h1234);
      for (int i = 0; i < 3; i++) begin
         cyc();
         memwb_regwen = 0;
         #1;
         chk("stl_PortA", PortA, 32'h1234);
         chk("stl_ALUOP", {28'd0, ALUOP}, 32'h7);
         chk("stl_wsel", {27'd0, ex_wsel}, 32'd10);
         chk("stl_valid", {31'd0, ex_valid}, 1);
      end
      stall = 0;

      // flush beats stall
      set_id(1, 32'h3, 32'h4, 32'h0, 0, 4'h5, 5'd1, 5'd2, 5'd3, 1);
      cyc();
      stall = 1; flush = 1;
      cyc();
      #1;
      chk("fl_valid", {31'd0, ex_valid}, 0);
      chk("fl_regwen", {31'd0, ex_regwen}, 0);
      chk("fl_ALUOP", {28'd0, ALUOP}, 0);
      flush = 0;

      // reset while stalled
      set_id(1, 32'h3, 32'h4, 32'h0, 0, 4'h5, 5'd1, 5'd2, 5'd3, 1);
      stall = 0;
      cyc();
      stall = 1; RST = 1;
      cyc();
      #1;
      chk("rs_valid", {31'd0, ex_valid}, 0);
      chk("rs_ALUOP", {28'd0, ALUOP}, 0);
      RST = 0; stall = 0;

      // randomized traffic, checked by the compare process
      for (int n = 0; n < 3000; n++) begin
         cyc();
         rand_id();
         set_prod(1'($urandom), 5'($urandom_range(0, 7)), $urandom,
                  1'($urandom), 5'($urandom_range(0, 7)), $urandom);
         stall = ($urandom_range(0, 3) == 0);
         flush = ($urandom_range(0, 15) == 0);
         RST   = ($urandom_range(0, 63) == 0);
      end
      cyc();
      @(negedge CLK);
      #1;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
